axis_frame_tx: RTL and testbench



---
 rtl/axis_frame_tx_if.sv | 13 +
 rtl/axis_frame_tx.sv | 181 ++++++++++++++++++
 tb/tb_axis_frame_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_tx_if.sv
// AXI4-Stream bundle between the frame transmitter and its downstream consumer.
interface axis_frame_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_tx.sv
// Frame transmitter: on a start pulse, reads frame_len words from a synchronous
// buffer starting at start_addr and emits them as one AXI4-Stream packet.
// A two-entry output buffer (output register + skid register) keeps one beat
// per clock under continuous tready and absorbs backpressure.
module axis_frame_tx #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH         = 11
) (
  input  logic                          m00_axis_aclk,
  input  logic                          m00_axis_areset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         start_addr,
  input  logic [ADDR_WIDTH:0]           frame_len,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] rd_data,
  axis_frame_tx_if.master               m00_axis
);

  localparam int STRB_WIDTH = C_AXIS_TDATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1'b1);
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = (ADDR_WIDTH+1)'(1'b0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                        state_r;
  logic [ADDR_WIDTH-1:0]         start_addr_r;
  logic [ADDR_WIDTH:0]           len_r;
  logic [ADDR_WIDTH:0]           issued_r;
  logic                          busy_r;
  logic                          done_r;
  // Read issued last cycle: its data is on rd_data this cycle.
  logic                          inflight_r;
  logic                          inflight_last_r;
  logic                          out_valid_r;
  logic [C_AXIS_TDATA_WIDTH-1:0] out_data_r;
  logic                          out_last_r;
  logic                          skid_valid_r;
  logic [C_AXIS_TDATA_WIDTH-1:0] skid_data_r;
  logic                          skid_last_r;

  logic                          hs_s;
  logic [1:0]                    occ_s;
  logic [1:0]                    occ_after_s;
  logic                          rd_en_s;
  logic                          is_last_read_s;

  // Read issue decision: a slot freed by this cycle's handshake may be reused at once.
  always_comb begin
    hs_s           = out_valid_r & m00_axis.tready;
    occ_s          = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, inflight_r};
    occ_after_s    = occ_s - {1'b0, hs_s};
    is_last_read_s = ((issued_r + CNT_ONE) == len_r);
    if ((state_r == ST_RUN) && (issued_r < len_r) && (occ_after_s < 2'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Frame control FSM: start capture, read counting, completion pulse.
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state_r      <= ST_IDLE;
      start_addr_r <= '0;
      len_r        <= '0;
      issued_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            start_addr_r <= start_addr;
            len_r        <= frame_len;
            issued_r     <= CNT_ZERO;
            busy_r       <= 1'b1;
            state_r      <= (frame_len == CNT_ZERO) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_en_s) begin
            issued_r <= issued_r + CNT_ONE;
            if (is_last_read_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (hs_s && out_last_r) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          // An empty frame arrives here still busy: spend one cycle busy, then pulse done.
          if (busy_r) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer: capture returning read data, shift skid into output on handshake.
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      out_valid_r     <= 1'b0;
      out_data_r      <= '0;
      out_last_r      <= 1'b0;
      skid_valid_r    <= 1'b0;
      skid_data_r     <= '0;
      skid_last_r     <= 1'b0;
    end else begin
      inflight_r      <= rd_en_s;
      inflight_last_r <= rd_en_s & is_last_read_s;
      if (hs_s) begin
        if (skid_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= skid_data_r;
          out_last_r  <= skid_last_r;
          if (inflight_r) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= rd_data;
            skid_last_r  <= inflight_last_r;
          end else begin
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
          end
        end else if (inflight_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= rd_data;
          out_last_r  <= inflight_last_r;
        end else begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      end else if (inflight_r) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          out_data_r  <= rd_data;
          out_last_r  <= inflight_last_r;
        end else begin
          skid_valid_r <= 1'b1;
          skid_data_r  <= rd_data;
          skid_last_r  <= inflight_last_r;
        end
      end
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign rd_en           = rd_en_s;
  assign rd_addr         = start_addr_r + issued_r[ADDR_WIDTH-1:0];
  assign m00_axis.tdata  = out_data_r;
  assign m00_axis.tvalid = out_valid_r;
  assign m00_axis.tlast  = out_last_r;
  assign m00_axis.tstrb  = {STRB_WIDTH{out_valid_r}};

endmodule

// File: tb/tb_axis_frame_tx.sv
// Self-checking bench for axis_frame_tx: table of frames plus random frames,
// each checked against a queue-based model of the expected reads and beats.
module tb_axis_frame_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] frame_len;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] mem [0:2047];

  int n_cmp = 0;
  int n_bad = 0;

  axis_frame_tx_if #(.DATA_WIDTH(32)) axis ();

  axis_frame_tx #(.C_AXIS_TDATA_WIDTH(32), .ADDR_WIDTH(11)) dut (
    .m00_axis_aclk  (clk),
    .m00_axis_areset(rst),
    .start          (start),
    .start_addr     (start_addr),
    .frame_len      (frame_len),
    .busy           (busy),
    .done           (done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .m00_axis       (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous buffer model: data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bad(input string name, input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_rd_en"},  rd_en, 0);
    chk({tag, "_rdaddr"}, rd_addr, 0);
    chk({tag, "_tvalid"}, axis.tvalid, 0);
    chk({tag, "_tdata"},  axis.tdata, 0);
    chk({tag, "_tstrb"},  axis.tstrb, 0);
    chk({tag, "_tlast"},  axis.tlast, 0);
  endtask

  function automatic bit ready_for(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: return bit'($urandom_range(0, 1));
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Runs one frame; the model is the list of addresses (start+k) mod 2048 and their words.
  task automatic run_frame(input int addr, input int len, input int mode, input bit spur,
                           input int exp_done, input bit has_last, input logic [31:0] exp_last);
    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_addr[$];
    int          reads = 0;
    int          beats = 0;
    int          last_hs = -1;
    int          done_cyc = -1;
    int          budget;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic        prev_last = 1'b0;
    logic [31:0] seen_last = 32'h0;
    bit          got_last = 1'b0;
    bit          hs;
    for (int k = 0; k < len; k++) begin
      q_addr.push_back((addr + k) % 2048);
      q_data.push_back(mem[(addr + k) % 2048]);
      q_last.push_back(k == len - 1);
    end
    budget = 4 * len + 50;
    @(posedge clk); #1;
    start = 1'b1; start_addr = addr[10:0]; frame_len = len[11:0]; axis.tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
      axis.tready = ready_for(mode, cyc);
      if (spur && cyc == 3) begin
        start = 1'b1; start_addr = 11'd7; frame_len = 12'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = axis.tvalid && axis.tready;
      if (cyc == 0 && len > 0) begin
        chk("rd_en_first", rd_en, 1);
        chk("rd_addr_first", rd_addr, addr);
      end
      chk("tstrb", axis.tstrb, {4{axis.tvalid}});
      chk("tlast_without_tvalid", axis.tlast & ~axis.tvalid, 0);
      if (rd_en) begin
        if (q_addr.size() == 0) bad("extra_read", "rd_en after all words read");
        else chk("rd_addr", rd_addr, q_addr.pop_front());
        reads++;
      end
      if (hs) begin
        beats++;
        if (q_data.size() == 0) begin
          bad("extra_beat", "beat after all words sent");
        end else begin
          chk("tdata", axis.tdata, q_data.pop_front());
          chk("tlast", axis.tlast, q_last.pop_front());
        end
        if (axis.tlast) begin
          got_last = 1'b1;
          seen_last = axis.tdata;
        end
        last_hs = cyc;
      end
      chk("outstanding_le_2", (reads - beats) <= 2, 1);
      if (prev_stall) begin
        chk("hold_tvalid", axis.tvalid, 1);
        chk("hold_tdata", axis.tdata, prev_data);
        chk("hold_tlast", axis.tlast, prev_last);
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        chk("done_after_last", cyc, (len == 0) ? 1 : last_hs + 1);
      end else begin
        chk("busy", busy, 1);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      bad("done_timeout", "no done within cycle budget");
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    end
    chk("beat_count", beats, len);
    chk("read_count", reads, len);
    if (has_last) begin
      chk("tlast_seen", got_last, 1);
      chk("tlast_word", seen_last, exp_last);
    end else begin
      chk("no_tlast", got_last, 0);
    end
  endtask

  typedef struct {
    int          addr;
    int          len;
    int          mode;
    bit          spur;
    int          exp_done;
    bit          has_last;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    bit hit;
    vecs[0] = '{0,    4,    0, 1'b0, 6,    1'b1, 32'hA3};
    vecs[1] = '{16,   8,    1, 1'b0, -1,   1'b1, 32'hB7};
    vecs[2] = '{32,   0,    0, 1'b0, 1,    1'b0, 32'h0};
    vecs[3] = '{48,   1,    0, 1'b0, 3,    1'b1, 32'hD0};
    vecs[4] = '{2046, 4,    0, 1'b0, 6,    1'b1, 32'hA1};
    vecs[5] = '{5,    2048, 0, 1'b0, 2050, 1'b1, 32'hA4};
    vecs[6] = '{100,  12,   1, 1'b1, -1,   1'b1, 32'h10F};
    vecs[7] = '{2040, 20,   2, 1'b0, -1,   1'b1, 32'hAB};
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA0 + i;

    rst = 1'b1; start = 1'b0; start_addr = 11'd0; frame_len = 12'd0; axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].spur,
                vecs[v].exp_done, vecs[v].has_last, vecs[v].exp_last);
    end

    // Reset during a frame after its third beat: outputs drop at once, no done.
    @(posedge clk); #1;
    start = 1'b1; start_addr = 11'd0; frame_len = 12'd10; axis.tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (axis.tvalid && axis.tready) cnt++;
      if (cnt == 3) hit = 1'b1;
      @(posedge clk); #1;
    end
    if (!hit) bad("abort_wait", "third beat never seen");
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_no_tvalid", axis.tvalid, 0);
    end
    rst = 1'b0;
    run_frame(50, 5, 0, 1'b0, 7, 1'b1, 32'hD6);

    // Random frames against the queue model.
    for (int r = 0; r < 6; r++) begin
      int ra;
      int rl;
      ra = $urandom_range(0, 2047);
      rl = $urandom_range(1, 40);
      run_frame(ra, rl, 2 + (r % 2), r[0], -1, 1'b1, mem[(ra + rl - 1) % 2048]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
